// File: rtl/a2d_scan.sv
// Round-robin multi-channel A2D scanner: two SPI transactions per enabled channel,
// results kept in per-channel registers. Includes the SPI_mnrch master it drives.

module SPI_mnrch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] wt_data,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);
    // state     | meaning
    // SPI_IDLE  | SS_n high, SCLK parked high, waiting for wrt
    // SPI_SHIFT | 16-bit exchange, SCLK = clk/16, MISO sampled on rise, shift on fall
    typedef enum logic {SPI_IDLE, SPI_SHIFT} spi_state_t;

    spi_state_t  state, state_nxt;
    logic [3:0]  sclk_div;
    logic [3:0]  bit_cnt;
    logic [15:0] shft_reg;
    logic        miso_smpl;
    logic        ld, shft, finish;
    logic        sclk_rise, sclk_fall;

    assign sclk_rise = (state == SPI_SHIFT) && (sclk_div == 4'b0111);
    assign sclk_fall = (state == SPI_SHIFT) && (sclk_div == 4'b1111);

    always_comb begin
        state_nxt = state;
        ld        = 1'b0;
        shft      = 1'b0;
        finish    = 1'b0;
        case (state)
            SPI_IDLE: begin
                if (wrt) begin
                    ld        = 1'b1;
                    state_nxt = SPI_SHIFT;
                end
            end
            SPI_SHIFT: begin
                if (sclk_fall) begin
                    shft = 1'b1;
                    if (bit_cnt == 4'd0) begin
                        finish    = 1'b1;
                        state_nxt = SPI_IDLE;
                    end
                end
            end
            default: state_nxt = SPI_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SPI_IDLE;
            sclk_div  <= 4'd0;
            bit_cnt   <= 4'd0;
            shft_reg  <= 16'h0000;
            miso_smpl <= 1'b0;
            SS_n      <= 1'b1;
            done      <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= finish;
            if (ld) begin
                shft_reg <= wt_data;
                sclk_div <= 4'd0;
                bit_cnt  <= 4'd15;
                SS_n     <= 1'b0;
            end else begin
                if (state == SPI_SHIFT)
                    sclk_div <= sclk_div + 4'd1;
                if (sclk_rise)
                    miso_smpl <= MISO;
                if (shft) begin
                    shft_reg <= {shft_reg[14:0], miso_smpl};
                    bit_cnt  <= bit_cnt - 4'd1;
                end
                if (finish)
                    SS_n <= 1'b1;
            end
        end
    end

    // The final falling edge is suppressed by returning to idle, so SCLK ends high.
    assign SCLK    = (state == SPI_IDLE) | sclk_div[3];
    assign MOSI    = shft_reg[15];
    assign rd_data = shft_reg;
endmodule

module a2d_scan #(
    parameter int NUM_CH   = 8,
    parameter int GAP_CLKS = 1,
    parameter int INVERT   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              strt_cnv,
    input  logic              cont,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [2:0]        rd_ch,
    output logic [11:0]       rd_res,
    output logic              smp_vld,
    output logic [2:0]        smp_ch,
    output logic [11:0]       smp_res,
    output logic              cnv_cmplt,
    output logic              busy,
    output logic              SS_n,
    output logic              SCLK,
    output logic              MOSI,
    input  logic              MISO
);
    // state | meaning
    // IDLE  | waiting for strt_cnv
    // CMD   | first transaction of cur_ch (sends channel command)
    // GAP   | idle clocks between transactions, phase selects the next one
    // RSP   | second transaction of cur_ch (returns its result)
    typedef enum logic [1:0] {IDLE, CMD, GAP, RSP} state_t;

    localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam logic [GW-1:0] GAP_LD = GW'(GAP_CLKS - 1);

    state_t            state, state_nxt;
    logic              phase_rsp, phase_rsp_nxt;
    logic [2:0]        cur_ch, cur_ch_nxt, cmd_ch;
    logic [NUM_CH-1:0] ch_mask, ch_mask_nxt;
    logic [GW-1:0]     gap_cnt, gap_cnt_nxt;
    logic              busy_nxt, smp_vld_nxt, cnv_nxt, store;
    logic              wrt, done;
    logic [15:0]       rd_data, cmd_word;
    logic [3:0]        rd_data_unused;
    logic [11:0]       result;
    logic [11:0]       res [NUM_CH];
    logic [3:0]        first_en, next_cur;

    // Returns {found, ch} for the lowest set bit of m at or above index from.
    function automatic logic [3:0] find_from(input logic [7:0] m, input int from);
        logic [3:0] r;
        r = 4'h0;
        for (int i = 7; i >= 0; i--)
            if (i >= from && m[i])
                r = {1'b1, 3'(i)};
        return r;
    endfunction

    assign first_en       = find_from(8'(ch_en), 0);
    assign next_cur       = find_from(8'(ch_mask), int'(cur_ch) + 1);
    assign cmd_word       = {2'b00, cmd_ch, 11'h000};
    assign result         = (INVERT != 0) ? ~rd_data[11:0] : rd_data[11:0];
    assign rd_data_unused = rd_data[15:12];

    always_comb begin
        state_nxt     = state;
        phase_rsp_nxt = phase_rsp;
        cur_ch_nxt    = cur_ch;
        ch_mask_nxt   = ch_mask;
        gap_cnt_nxt   = gap_cnt;
        busy_nxt      = busy;
        smp_vld_nxt   = 1'b0;
        cnv_nxt       = 1'b0;
        store         = 1'b0;
        wrt           = 1'b0;
        cmd_ch        = cur_ch;
        case (state)
            IDLE: begin
                if (strt_cnv) begin
                    ch_mask_nxt = ch_en;
                    if (first_en[3]) begin
                        cur_ch_nxt = first_en[2:0];
                        cmd_ch     = first_en[2:0];
                        wrt        = 1'b1;
                        busy_nxt   = 1'b1;
                        state_nxt  = CMD;
                    end else begin
                        cnv_nxt = 1'b1;
                    end
                end
            end
            CMD: begin
                if (done) begin
                    gap_cnt_nxt   = GAP_LD;
                    phase_rsp_nxt = 1'b1;
                    state_nxt     = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    wrt       = 1'b1;
                    state_nxt = phase_rsp ? RSP : CMD;
                end else begin
                    gap_cnt_nxt = gap_cnt - GW'(1);
                end
            end
            RSP: begin
                if (done) begin
                    store       = 1'b1;
                    smp_vld_nxt = 1'b1;
                    if (next_cur[3]) begin
                        cur_ch_nxt    = next_cur[2:0];
                        phase_rsp_nxt = 1'b0;
                        gap_cnt_nxt   = GAP_LD;
                        state_nxt     = GAP;
                    end else begin
                        cnv_nxt = 1'b1;
                        if (cont)
                            ch_mask_nxt = ch_en;
                        if (cont && first_en[3]) begin
                            cur_ch_nxt    = first_en[2:0];
                            phase_rsp_nxt = 1'b0;
                            gap_cnt_nxt   = GAP_LD;
                            state_nxt     = GAP;
                        end else begin
                            busy_nxt  = 1'b0;
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            phase_rsp <= 1'b0;
            cur_ch    <= 3'd0;
            ch_mask   <= '0;
            gap_cnt   <= '0;
            busy      <= 1'b0;
            smp_vld   <= 1'b0;
            cnv_cmplt <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase_rsp <= phase_rsp_nxt;
            cur_ch    <= cur_ch_nxt;
            ch_mask   <= ch_mask_nxt;
            gap_cnt   <= gap_cnt_nxt;
            busy      <= busy_nxt;
            smp_vld   <= smp_vld_nxt;
            cnv_cmplt <= cnv_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_ch  <= 3'd0;
            smp_res <= 12'h000;
            for (int i = 0; i < NUM_CH; i++)
                res[i] <= 12'h000;
        end else if (store) begin
            smp_ch      <= cur_ch;
            smp_res     <= result;
            res[cur_ch] <= result;
        end
    end

    always_comb begin
        rd_res = 12'h000;
        if (int'(rd_ch) < NUM_CH)
            rd_res = res[rd_ch];
    end

    SPI_mnrch u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt),
        .wt_data (cmd_word),
        .done    (done),
        .rd_data (rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );
endmodule

// File: tb/tb_a2d_scan.sv
// Directed bench for a2d_scan: three instances (base, inverted, wide gap) share one
// A2D model on a wired SPI bus; only one instance scans at a time.

module tb_a2d_scan;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       cont;
    logic [7:0] ch_en;
    logic [2:0] rd_ch;
    logic       strt [3];
    logic [11:0] rd_res_a [3];
    logic        smp_vld_a [3];
    logic [2:0]  smp_ch_a [3];
    logic [11:0] smp_res_a [3];
    logic        cnv_a [3];
    logic        busy_a [3];
    logic        ss_n_a [3];
    logic        sclk_a [3];
    logic        mosi_a [3];
    logic        miso, ss_n, sclk, mosi;

    int errors = 0;
    int checks = 0;
    int sel = 0;

    always #10 clk = ~clk;

    a2d_scan #(.NUM_CH(8), .GAP_CLKS(1), .INVERT(0)) dut (
        .clk(clk), .rst_n(rst_n), .strt_cnv(strt[0]), .cont(cont), .ch_en(ch_en), .rd_ch(rd_ch),
        .rd_res(rd_res_a[0]), .smp_vld(smp_vld_a[0]), .smp_ch(smp_ch_a[0]), .smp_res(smp_res_a[0]),
        .cnv_cmplt(cnv_a[0]), .busy(busy_a[0]), .SS_n(ss_n_a[0]), .SCLK(sclk_a[0]), .MOSI(mosi_a[0]),
        .MISO(miso));

    a2d_scan #(.NUM_CH(8), .GAP_CLKS(1), .INVERT(1)) dut_inv (
        .clk(clk), .rst_n(rst_n), .strt_cnv(strt[1]), .cont(cont), .ch_en(ch_en), .rd_ch(rd_ch),
        .rd_res(rd_res_a[1]), .smp_vld(smp_vld_a[1]), .smp_ch(smp_ch_a[1]), .smp_res(smp_res_a[1]),
        .cnv_cmplt(cnv_a[1]), .busy(busy_a[1]), .SS_n(ss_n_a[1]), .SCLK(sclk_a[1]), .MOSI(mosi_a[1]),
        .MISO(miso));

    a2d_scan #(.NUM_CH(8), .GAP_CLKS(4), .INVERT(0)) dut_gap (
        .clk(clk), .rst_n(rst_n), .strt_cnv(strt[2]), .cont(cont), .ch_en(ch_en), .rd_ch(rd_ch),
        .rd_res(rd_res_a[2]), .smp_vld(smp_vld_a[2]), .smp_ch(smp_ch_a[2]), .smp_res(smp_res_a[2]),
        .cnv_cmplt(cnv_a[2]), .busy(busy_a[2]), .SS_n(ss_n_a[2]), .SCLK(sclk_a[2]), .MOSI(mosi_a[2]),
        .MISO(miso));

    assign ss_n = ss_n_a[0] & ss_n_a[1] & ss_n_a[2];
    assign sclk = sclk_a[0] & sclk_a[1] & sclk_a[2];
    assign mosi = !ss_n_a[0] ? mosi_a[0] : (!ss_n_a[1] ? mosi_a[1] : mosi_a[2]);

    logic        m_smp_vld, m_cnv, m_busy;
    logic [2:0]  m_smp_ch;
    logic [11:0] m_smp_res;
    assign m_smp_vld = smp_vld_a[sel];
    assign m_smp_ch  = smp_ch_a[sel];
    assign m_smp_res = smp_res_a[sel];
    assign m_cnv     = cnv_a[sel];
    assign m_busy    = busy_a[sel];

    // A2D model: answers with the channel named in the previous command.
    logic [15:0] tx = 16'h0000;
    logic [15:0] rx = 16'h0000;
    logic [2:0]  last_ch = 3'd0;
    logic        seen_rise = 1'b0;
    int          ss_lows = 0;
    logic [15:0] cmd_q [$];

    function automatic logic [11:0] a2d_val(input int ch);
        return 12'(256 * ch + 35);
    endfunction

    assign miso = tx[15];

    always @(negedge ss_n) begin
        tx        = {4'h0, a2d_val(int'(last_ch))};
        seen_rise = 1'b0;
        ss_lows++;
    end
    always @(posedge sclk) if (ss_n === 1'b0) begin
        rx        = {rx[14:0], mosi};
        seen_rise = 1'b1;
    end
    always @(negedge sclk) if (ss_n === 1'b0 && seen_rise) tx = {tx[14:0], 1'b0};
    always @(posedge ss_n) begin
        last_ch = rx[13:11];
        cmd_q.push_back(rx);
    end

    // Sample/completion monitor; cnv entry holds the sample count when coincident, else -1.
    logic [2:0]  smp_ch_q [$];
    logic [11:0] smp_res_q [$];
    int          cnv_n_q [$];
    int          hi_run = 0;
    int          gap_q [$];
    logic        ss_prev = 1'b1;

    always @(negedge clk) begin
        if (m_smp_vld === 1'b1) begin
            smp_ch_q.push_back(m_smp_ch);
            smp_res_q.push_back(m_smp_res);
        end
        if (m_cnv === 1'b1)
            cnv_n_q.push_back(m_smp_vld === 1'b1 ? smp_ch_q.size() : -1);
        if (ss_n === 1'b1)
            hi_run++;
        else if (ss_prev === 1'b1) begin
            gap_q.push_back(hi_run);
            hi_run = 0;
        end
        ss_prev = ss_n;
    end

    task automatic pulse_start(input int idx);
        @(negedge clk);
        strt[idx] = 1'b1;
        @(negedge clk);
        strt[idx] = 1'b0;
    endtask

    task automatic wait_idle(input int limit, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (m_busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        strt[0] = 1'b0; strt[1] = 1'b0; strt[2] = 1'b0;
        cont = 1'b0; ch_en = 8'h00; rd_ch = 3'd0; sel = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({m_busy, m_smp_vld, m_cnv, ss_n, sclk} !== 5'b00011) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00011", {m_busy, m_smp_vld, m_cnv, ss_n, sclk});
        end
        checks++;
        if ({m_smp_ch, m_smp_res} !== 15'h0) begin
            errors++;
            $display("FAIL reset_smp: got %h expected 0", {m_smp_ch, m_smp_res});
        end
        for (int i = 0; i < 8; i++) begin
            rd_ch = 3'(i);
            #1;
            checks++;
            if (rd_res_a[0] !== 12'h000) begin
                errors++;
                $display("FAIL reset_res%0d: got %h expected 000", i, rd_res_a[0]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_scan();
        int s0, c0, k0, l0, g0;
        bit ok;
        sel = 0; ch_en = 8'hFF; cont = 1'b0;
        s0 = smp_ch_q.size(); c0 = cnv_n_q.size(); k0 = cmd_q.size(); l0 = ss_lows; g0 = gap_q.size();
        pulse_start(0);
        checks++;
        if (m_busy !== 1'b1) begin
            errors++;
            $display("FAIL full_busy: got %b expected 1", m_busy);
        end
        wait_idle(20000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL full_timeout: got busy expected idle"); end
        checks++;
        if (smp_ch_q.size() - s0 != 8) begin
            errors++;
            $display("FAIL full_count: got %0d expected 8", smp_ch_q.size() - s0);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (s0 + i >= smp_ch_q.size() || smp_ch_q[s0+i] !== 3'(i) || smp_res_q[s0+i] !== a2d_val(i)) begin
                errors++;
                $display("FAIL full_smp%0d: got ch %0d res %h expected ch %0d res %h", i,
                         smp_ch_q[s0+i], smp_res_q[s0+i], i, a2d_val(i));
            end
        end
        checks++;
        if (cnv_n_q.size() - c0 != 1 || cnv_n_q[c0] != s0 + 8) begin
            errors++;
            $display("FAIL full_cnv: got %0d pulses (first at %0d) expected 1 at %0d",
                     cnv_n_q.size() - c0, cnv_n_q[c0], s0 + 8);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (cmd_q[k0+i] !== {2'b00, 3'(i / 2), 11'h000}) begin
                errors++;
                $display("FAIL full_cmd%0d: got %h expected %h", i, cmd_q[k0+i], {2'b00, 3'(i / 2), 11'h000});
            end
        end
        checks++;
        if (ss_lows - l0 != 16) begin
            errors++;
            $display("FAIL full_ss_lows: got %0d expected 16", ss_lows - l0);
        end
        // With GAP_CLKS=1 SS_n is high for the done clock plus one gap clock.
        for (int i = 1; i < 16; i++) begin
            checks++;
            if (gap_q[g0+i] != 2) begin
                errors++;
                $display("FAIL full_gap%0d: got %0d expected 2", i, gap_q[g0+i]);
            end
        end
        rd_ch = 3'd5;
        @(negedge clk);
        checks++;
        if (rd_res_a[0] !== 12'h523) begin
            errors++;
            $display("FAIL full_rd5: got %h expected 523", rd_res_a[0]);
        end
    endtask

    task automatic test_mask();
        int s0, c0, l0;
        bit ok;
        int exp_ch [3] = '{2, 5, 7};
        apply_reset();
        sel = 0; ch_en = 8'b1010_0100; cont = 1'b0;
        s0 = smp_ch_q.size(); c0 = cnv_n_q.size(); l0 = ss_lows;
        pulse_start(0);
        ch_en = 8'hFF;
        wait_idle(20000, ok);
        checks++;
        if (!ok || smp_ch_q.size() - s0 != 3) begin
            errors++;
            $display("FAIL mask_count: got %0d samples expected 3", smp_ch_q.size() - s0);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (smp_ch_q[s0+i] !== 3'(exp_ch[i]) || smp_res_q[s0+i] !== a2d_val(exp_ch[i])) begin
                errors++;
                $display("FAIL mask_smp%0d: got ch %0d res %h expected ch %0d res %h", i,
                         smp_ch_q[s0+i], smp_res_q[s0+i], exp_ch[i], a2d_val(exp_ch[i]));
            end
        end
        checks++;
        if (ss_lows - l0 != 6 || cnv_n_q.size() - c0 != 1) begin
            errors++;
            $display("FAIL mask_ss_cnv: got %0d lows %0d cnv expected 6 lows 1 cnv",
                     ss_lows - l0, cnv_n_q.size() - c0);
        end
        rd_ch = 3'd0;
        #1;
        checks++;
        if (rd_res_a[0] !== 12'h000) begin
            errors++;
            $display("FAIL mask_res0: got %h expected 000", rd_res_a[0]);
        end
    endtask

    task automatic test_invert();
        int s0;
        bit ok;
        sel = 1; ch_en = 8'h08; cont = 1'b0;
        s0 = smp_ch_q.size();
        pulse_start(1);
        wait_idle(20000, ok);
        checks++;
        if (!ok || smp_ch_q.size() - s0 != 1 || smp_ch_q[s0] !== 3'd3 || smp_res_q[s0] !== 12'hCDC) begin
            errors++;
            $display("FAIL inv_smp: got %0d samples ch %0d res %h expected 1 ch 3 res CDC",
                     smp_ch_q.size() - s0, smp_ch_q[s0], smp_res_q[s0]);
        end
        rd_ch = 3'd3;
        #1;
        checks++;
        if (rd_res_a[1] !== 12'hCDC) begin
            errors++;
            $display("FAIL inv_rd3: got %h expected CDC", rd_res_a[1]);
        end
    endtask

    task automatic test_cont();
        int s0, c0;
        bit ok;
        sel = 0; ch_en = 8'h03; cont = 1'b1;
        s0 = smp_ch_q.size(); c0 = cnv_n_q.size();
        pulse_start(0);
        ok = 1'b0;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (cnv_n_q.size() - c0 >= 3) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL cont_three_scans: got %0d expected 3", cnv_n_q.size() - c0); end
        repeat (300) @(negedge clk);
        pulse_start(0);
        cont = 1'b0;
        checks++;
        if (m_busy !== 1'b1) begin
            errors++;
            $display("FAIL cont_busy_mid: got %b expected 1", m_busy);
        end
        wait_idle(20000, ok);
        repeat (20) @(negedge clk);
        checks++;
        if (!ok || m_busy !== 1'b0 || smp_ch_q.size() - s0 != 8 || cnv_n_q.size() - c0 != 4) begin
            errors++;
            $display("FAIL cont_total: got %0d samples %0d cnv busy %b expected 8 samples 4 cnv busy 0",
                     smp_ch_q.size() - s0, cnv_n_q.size() - c0, m_busy);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (smp_ch_q[s0+i] !== 3'(i % 2) || smp_res_q[s0+i] !== a2d_val(i % 2)) begin
                errors++;
                $display("FAIL cont_smp%0d: got ch %0d res %h expected ch %0d", i,
                         smp_ch_q[s0+i], smp_res_q[s0+i], i % 2);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cnv_n_q[c0+i] != s0 + 2 * (i + 1)) begin
                errors++;
                $display("FAIL cont_cnv%0d: got %0d expected %0d", i, cnv_n_q[c0+i], s0 + 2 * (i + 1));
            end
        end
    endtask

    task automatic test_empty_mask();
        int s0;
        sel = 0; ch_en = 8'h00; cont = 1'b0;
        s0 = smp_ch_q.size();
        @(negedge clk);
        strt[0] = 1'b1;
        @(negedge clk);
        strt[0] = 1'b0;
        checks++;
        if ({m_cnv, m_busy, ss_n} !== 3'b101) begin
            errors++;
            $display("FAIL empty_cnv: got %b expected 101", {m_cnv, m_busy, ss_n});
        end
        @(negedge clk);
        checks++;
        if (m_cnv !== 1'b0 || m_busy !== 1'b0 || smp_ch_q.size() != s0) begin
            errors++;
            $display("FAIL empty_after: got cnv %b busy %b samples %0d expected 0 0 0",
                     m_cnv, m_busy, smp_ch_q.size() - s0);
        end
    endtask

    task automatic test_gap();
        int s0, g0;
        bit ok;
        sel = 2; ch_en = 8'h06; cont = 1'b0;
        s0 = smp_ch_q.size(); g0 = gap_q.size();
        pulse_start(2);
        wait_idle(20000, ok);
        checks++;
        if (!ok || smp_ch_q.size() - s0 != 2 || smp_res_q[s0] !== 12'h123 || smp_res_q[s0+1] !== 12'h223) begin
            errors++;
            $display("FAIL gap_smp: got %0d samples %h %h expected 2 samples 123 223",
                     smp_ch_q.size() - s0, smp_res_q[s0], smp_res_q[s0+1]);
        end
        checks++;
        if (gap_q.size() - g0 != 4) begin
            errors++;
            $display("FAIL gap_count: got %0d expected 4", gap_q.size() - g0);
        end
        // Each high run is the done clock followed by the gap clocks.
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (gap_q[g0+i] - 1 != 4) begin
                errors++;
                $display("FAIL gap_len%0d: got %0d expected 4", i, gap_q[g0+i] - 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        int s0, c0, l0;
        bit ok;
        sel = 0; ch_en = 8'hFF; cont = 1'b0;
        s0 = smp_ch_q.size(); c0 = cnv_n_q.size(); l0 = ss_lows;
        pulse_start(0);
        ok = 1'b0;
        for (int k = 0; k < 20000; k++) begin
            @(negedge clk);
            if (ss_lows - l0 >= 10) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL mid_reach_ch4: got %0d lows expected 10", ss_lows - l0); end
        repeat (50) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ss_n !== 1'b1) begin
            errors++;
            $display("FAIL mid_ss_async: got %b expected 1", ss_n);
        end
        @(negedge clk);
        checks++;
        if (smp_ch_q.size() - s0 != 4 || cnv_n_q.size() != c0 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_abort: got %0d samples %0d cnv busy %b expected 4 0 0",
                     smp_ch_q.size() - s0, cnv_n_q.size() - c0, m_busy);
        end
        for (int i = 0; i < 8; i++) begin
            rd_ch = 3'(i);
            #1;
            checks++;
            if (rd_res_a[0] !== 12'h000) begin
                errors++;
                $display("FAIL mid_res%0d: got %h expected 000", i, rd_res_a[0]);
            end
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ch_en = 8'h30;
        s0 = smp_ch_q.size(); c0 = cnv_n_q.size();
        pulse_start(0);
        wait_idle(20000, ok);
        checks++;
        if (!ok || smp_ch_q.size() - s0 != 2 || smp_res_q[s0] !== 12'h423 || smp_res_q[s0+1] !== 12'h523
            || cnv_n_q.size() - c0 != 1) begin
            errors++;
            $display("FAIL mid_rescan: got %0d samples %h %h %0d cnv expected 2 423 523 1",
                     smp_ch_q.size() - s0, smp_res_q[s0], smp_res_q[s0+1], cnv_n_q.size() - c0);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_scan();
        test_mask();
        test_invert();
        test_cont();
        test_empty_mask();
        test_gap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/a2d_scan.md
# a2d_scan

Parametrised round-robin A2D scanner, the multi-channel successor to the single-conversion A2D interface. On a start request it converts every enabled channel in ascending order, two SPI transactions per channel, and stores each 12-bit result in a per-channel register. A scan can repeat continuously. It sits between the IR/sensor consumers and the off-chip A2D, reusing the existing `SPI_mnrch` master internally.

## Interface
- `NUM_CH`, default 8: number of scanned channels, 1–8. Channel index equals A2D channel number.
- `GAP_CLKS`, default 1: idle clocks between consecutive SPI transactions, ≥1.
- `INVERT`, default 0: 1 stores the 1's complement of the result (light line on dark background).
- `clk`, in, 1: 50 MHz system clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `strt_cnv`, in, 1: start-scan pulse. Ignored while `busy`.
- `cont`, in, 1: continuous mode. Level sampled at end of each scan.
- `ch_en`, in, NUM_CH: channel enable mask. Latched at scan start.
- `rd_ch`, in, 3: read-port channel select.
- `rd_res`, out, 12: combinational `res[rd_ch]`. 0 if `rd_ch`≥NUM_CH.
- `smp_vld`, out, 1: 1-clk pulse, a new sample was stored.
- `smp_ch`, out, 3: channel of the latest stored sample.
- `smp_res`, out, 12: value of the latest stored sample, after inversion.
- `cnv_cmplt`, out, 1: 1-clk pulse, full scan finished.
- `busy`, out, 1: high from scan start until return to IDLE.
- `SS_n`, `SCLK`, `MOSI`, out, 1 each; `MISO`, in, 1: SPI to the A2D, driven by internal `SPI_mnrch`.

## Operation
- Command word: {2'b00, ch[2:0], 11'h000}.
- Result: `rd_data[11:0]` of the second transaction, inverted if INVERT=1.
- States and transitions:
  - IDLE: on `strt_cnv` with latched mask ≠0:
    - load `cur_ch` = lowest enabled channel;
    - assert `wrt` with its command; set `busy`;
    - go CMD.
  - IDLE, `strt_cnv` with mask=0: pulse `cnv_cmplt` the next cycle, stay IDLE, `busy` stays 0.
  - CMD: wait for `done`, then clear the gap counter, set phase=RSP, go GAP.
  - GAP: count GAP_CLKS clocks. In the last gap clock, assert `wrt` with the `cur_ch` command and go to the state named by phase (CMD or RSP).
  - RSP: on `done`:
    - write `res[cur_ch]`; drive `smp_vld`, `smp_ch`, `smp_res`;
    - if a higher enabled channel exists: `cur_ch` = next enabled channel, phase=CMD, go GAP;
    - else (last channel): pulse `cnv_cmplt` in the same cycle as `smp_vld`;
      - `cont`=1: relatch `ch_en`, `cur_ch` = lowest enabled channel, phase=CMD, go GAP;
      - `cont`=0, or relatched mask=0: go IDLE, drop `busy`.
- `ch_en` changes mid-scan take effect only at the next scan start.
- `strt_cnv` during `busy` is dropped, not queued.
- Result registers hold their last value until rewritten. Disabled channels keep stale values.

## Timing
- Reset values:
  - state IDLE; `busy`, `smp_vld`, `cnv_cmplt` = 0;
  - `smp_ch`, `smp_res`, all `res[]` = 0;
  - `SS_n`=1 and `SCLK`/`MOSI` at `SPI_mnrch` reset levels.
- `wrt` is a single-clock pulse. `done` from `SPI_mnrch` is honoured only in CMD/RSP, never in the `wrt` cycle.
- Per channel: T_spi + GAP_CLKS + T_spi + GAP_CLKS clocks (last gap omitted for the final channel), where T_spi is the `SPI_mnrch` transaction length from `wrt` to `done`.
- A stored result is readable on `rd_res` the clock after `smp_vld`.
- Reset asserted mid-transaction aborts immediately:
  - `SS_n` rises asynchronously;
  - no partial result is written;
  - no `cnv_cmplt` is issued.
- `cont` falling mid-scan: the current scan completes, then IDLE.

## Test plan
- A2D model returns 12'h100*ch+12'h023. Setup: NUM_CH=8, `ch_en`=8'hFF, INVERT=0, one `strt_cnv` pulse. Required:
  - 8 `smp_vld` pulses in order, ch0..7, with `smp_res` 12'h023..12'h723;
  - exactly one `cnv_cmplt`, coincident with the 8th `smp_vld`;
  - `rd_ch`=5 then reads 12'h523;
  - MOSI commands 0x0000, 0x0800, … per channel.
- `ch_en`=8'b1010_0100 -> samples only ch2, 5, 7, in that order. `res[0]` stays 0. Exactly 6 `SS_n` low periods.
- INVERT=1, ch3 only -> `smp_res`=~12'h323=12'hCDC.
- `cont`=1 with `ch_en`=8'h03 -> repeated 2-sample scans with a `cnv_cmplt` per scan. Drop `cont` mid-scan -> that scan finishes, then `busy`=0. Extra `strt_cnv` while busy produces no extra scan.
- GAP_CLKS=4 -> exactly 4 clocks of `SS_n` high between each `done` and the next `SS_n` fall.
- Assert `rst_n` low during ch4's RSP transaction -> `SS_n`=1 immediately, all `res[]`=0, no `cnv_cmplt`; a subsequent `strt_cnv` completes a normal scan.
